// File: rtl/ef_bus_arbiter.sv
// Round-robin arbiter and strobe sequencer for the shared Flash/Ethernet external bus.
// Optional read turnaround cycle is enabled by defining EF_ARB_TURNAROUND_EN.
module ef_bus_arbiter #(
    parameter int AW        = 23,
    parameter int FL_SETUP  = 2,
    parameter int FL_STROBE = 4,
    parameter int FL_HOLD   = 1,
    parameter int EN_SETUP  = 1,
    parameter int EN_STROBE = 3,
    parameter int EN_HOLD   = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fl_req,
    input  logic          fl_we,
    input  logic [AW-1:0] fl_adr,
    input  logic [31:0]   fl_wdata,
    output logic          fl_ack,
    input  logic          en_req,
    input  logic          en_we,
    input  logic [3:0]    en_be_n,
    input  logic [AW-1:0] en_adr,
    input  logic [31:0]   en_wdata,
    output logic          en_ack,
    output logic [31:0]   rdata,
    output logic [AW-1:0] ef_a,
    output logic [31:0]   ef_d_o,
    output logic          ef_d_oe,
    input  logic [31:0]   ef_d_i,
    output logic          flash_ce_n,
    output logic          flash_oe_n,
    output logic          flash_we_n,
    output logic          enet_rd_n,
    output logic          enet_wr_n,
    output logic [3:0]    enet_be_n
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
`ifdef EF_ARB_TURNAROUND_EN
        S_TURN,
`endif
        S_HOLD
    } state_e;

    typedef enum logic { OWN_FL, OWN_EN } owner_e;

    localparam logic [3:0] FL_SU = 4'(FL_SETUP);
    localparam logic [3:0] FL_ST = (FL_STROBE == 0) ? 4'd1 : 4'(FL_STROBE);
    localparam logic [3:0] FL_HO = 4'(FL_HOLD);
    localparam logic [3:0] EN_SU = 4'(EN_SETUP);
    localparam logic [3:0] EN_ST = (EN_STROBE == 0) ? 4'd1 : 4'(EN_STROBE);
    localparam logic [3:0] EN_HO = 4'(EN_HOLD);

    function automatic logic [3:0] setup_of(owner_e o);
        return (o == OWN_FL) ? FL_SU : EN_SU;
    endfunction
    function automatic logic [3:0] strobe_of(owner_e o);
        return (o == OWN_FL) ? FL_ST : EN_ST;
    endfunction
    function automatic logic [3:0] hold_of(owner_e o);
        return (o == OWN_FL) ? FL_HO : EN_HO;
    endfunction

    state_e        state_q, state_d, done_state;
    owner_e        own_q, own_d, last_q, last_d, win;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [AW-1:0] ef_a_q, ef_a_d;
    logic [31:0]   ef_d_o_q, ef_d_o_d;
    logic          ef_d_oe_q, ef_d_oe_d;
    logic          flash_ce_n_q, flash_ce_n_d, flash_oe_n_q, flash_oe_n_d;
    logic          flash_we_n_q, flash_we_n_d, enet_rd_n_q, enet_rd_n_d;
    logic          enet_wr_n_q, enet_wr_n_d;
    logic [3:0]    enet_be_n_q, enet_be_n_d;
    logic          fl_ack_q, fl_ack_d, en_ack_q, en_ack_d;
    logic          active, strobing, is_fl, last_cycle;

    // On a tie the requester not served last wins.
    assign win = (fl_req && en_req) ? ((last_q == OWN_EN) ? OWN_FL : OWN_EN)
                                    : (fl_req ? OWN_FL : OWN_EN);

    // NOTE: combinational blocks use blocking '=' and assign every output first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        own_d   = own_q;
        last_d  = last_q;
        we_d    = we_q;
        adr_d   = adr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
`ifdef EF_ARB_TURNAROUND_EN
        done_state = we_q ? S_IDLE : S_TURN;
`else
        done_state = S_IDLE;
`endif
        case (state_q)
            S_IDLE: begin
                if (fl_req || en_req) begin
                    own_d   = win;
                    last_d  = win;
                    we_d    = (win == OWN_FL) ? fl_we : en_we;
                    adr_d   = (win == OWN_FL) ? fl_adr : en_adr;
                    wdata_d = (win == OWN_FL) ? fl_wdata : en_wdata;
                    be_d    = (win == OWN_FL) ? 4'hF : en_be_n;
                    if (setup_of(win) != 4'd0) begin
                        state_d = S_SETUP;
                        cnt_d   = setup_of(win);
                    end else begin
                        state_d = S_STROBE;
                        cnt_d   = strobe_of(win);
                    end
                end
            end
            S_SETUP: begin
                if (cnt_q == 4'd1) begin
                    state_d = S_STROBE;
                    cnt_d   = strobe_of(own_q);
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_STROBE: begin
                if (cnt_q == 4'd1) begin
                    if (!we_q) rdata_d = ef_d_i;
                    if (hold_of(own_q) != 4'd0) begin
                        state_d = S_HOLD;
                        cnt_d   = hold_of(own_q);
                    end else begin
                        state_d = done_state;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_HOLD: begin
                if (cnt_q == 4'd1) state_d = done_state;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = S_IDLE;
        endcase

        // Pins are registered from the next-state view so they line up with the state they describe.
        active     = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
        strobing   = (state_d == S_STROBE);
        is_fl      = (own_d == OWN_FL);
        last_cycle = (cnt_d == 4'd1) &&
                     ((state_d == S_HOLD) || (strobing && hold_of(own_d) == 4'd0));

        ef_a_d       = adr_d;
        ef_d_o_d     = wdata_d;
        ef_d_oe_d    = active && we_d;
        flash_ce_n_d = !(active && is_fl);
        flash_oe_n_d = !(strobing && is_fl && !we_d);
        flash_we_n_d = !(strobing && is_fl && we_d);
        enet_rd_n_d  = !(strobing && !is_fl && !we_d);
        enet_wr_n_d  = !(strobing && !is_fl && we_d);
        enet_be_n_d  = (active && !is_fl) ? be_d : 4'hF;
        fl_ack_d     = last_cycle && is_fl;
        en_ack_d     = last_cycle && !is_fl;
    end

    // NOTE: sequential state uses non-blocking '<=' and the reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            own_q        <= OWN_EN;
            last_q       <= OWN_EN;
            we_q         <= 1'b0;
            adr_q        <= '0;
            wdata_q      <= '0;
            be_q         <= 4'hF;
            rdata_q      <= '0;
            ef_a_q       <= '0;
            ef_d_o_q     <= '0;
            ef_d_oe_q    <= 1'b0;
            flash_ce_n_q <= 1'b1;
            flash_oe_n_q <= 1'b1;
            flash_we_n_q <= 1'b1;
            enet_rd_n_q  <= 1'b1;
            enet_wr_n_q  <= 1'b1;
            enet_be_n_q  <= 4'hF;
            fl_ack_q     <= 1'b0;
            en_ack_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            own_q        <= own_d;
            last_q       <= last_d;
            we_q         <= we_d;
            adr_q        <= adr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            rdata_q      <= rdata_d;
            ef_a_q       <= ef_a_d;
            ef_d_o_q     <= ef_d_o_d;
            ef_d_oe_q    <= ef_d_oe_d;
            flash_ce_n_q <= flash_ce_n_d;
            flash_oe_n_q <= flash_oe_n_d;
            flash_we_n_q <= flash_we_n_d;
            enet_rd_n_q  <= enet_rd_n_d;
            enet_wr_n_q  <= enet_wr_n_d;
            enet_be_n_q  <= enet_be_n_d;
            fl_ack_q     <= fl_ack_d;
            en_ack_q     <= en_ack_d;
        end
    end

    assign fl_ack     = fl_ack_q;
    assign en_ack     = en_ack_q;
    assign rdata      = rdata_q;
    assign ef_a       = ef_a_q;
    assign ef_d_o     = ef_d_o_q;
    assign ef_d_oe    = ef_d_oe_q;
    assign flash_ce_n = flash_ce_n_q;
    assign flash_oe_n = flash_oe_n_q;
    assign flash_we_n = flash_we_n_q;
    assign enet_rd_n  = enet_rd_n_q;
    assign enet_wr_n  = enet_wr_n_q;
    assign enet_be_n  = enet_be_n_q;

endmodule

// File: tb/tb_ef_bus_arbiter.sv
// Bench for ef_bus_arbiter: two instances (default timing, and zero setup/hold variants)
// checked cycle by cycle against a transaction-level timing model.
module tb_ef_bus_arbiter;

    localparam int AW = 23;
`ifdef EF_ARB_TURNAROUND_EN
    localparam bit TURN = 1'b1;
`else
    localparam bit TURN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]    fl_req, en_req;
    logic          fl_we, en_we;
    logic [AW-1:0] fl_adr, en_adr;
    logic [31:0]   fl_wdata, en_wdata, ef_d_i;
    logic [3:0]    en_be_n_in;

    logic [1:0]    fl_ack, en_ack, ef_d_oe, flash_ce_n, flash_oe_n, flash_we_n, enet_rd_n, enet_wr_n;
    logic [31:0]   rdata [2];
    logic [31:0]   ef_d_o [2];
    logic [AW-1:0] ef_a [2];
    logic [3:0]    enet_be_n [2];

    ef_bus_arbiter u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .fl_req(fl_req[0]), .fl_we(fl_we), .fl_adr(fl_adr), .fl_wdata(fl_wdata), .fl_ack(fl_ack[0]),
        .en_req(en_req[0]), .en_we(en_we), .en_be_n(en_be_n_in), .en_adr(en_adr), .en_wdata(en_wdata),
        .en_ack(en_ack[0]), .rdata(rdata[0]), .ef_a(ef_a[0]), .ef_d_o(ef_d_o[0]), .ef_d_oe(ef_d_oe[0]),
        .ef_d_i(ef_d_i), .flash_ce_n(flash_ce_n[0]), .flash_oe_n(flash_oe_n[0]), .flash_we_n(flash_we_n[0]),
        .enet_rd_n(enet_rd_n[0]), .enet_wr_n(enet_wr_n[0]), .enet_be_n(enet_be_n[0])
    );

    ef_bus_arbiter #(
        .FL_SETUP(0), .FL_STROBE(4), .FL_HOLD(0),
        .EN_SETUP(0), .EN_STROBE(0), .EN_HOLD(2)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .fl_req(fl_req[1]), .fl_we(fl_we), .fl_adr(fl_adr), .fl_wdata(fl_wdata), .fl_ack(fl_ack[1]),
        .en_req(en_req[1]), .en_we(en_we), .en_be_n(en_be_n_in), .en_adr(en_adr), .en_wdata(en_wdata),
        .en_ack(en_ack[1]), .rdata(rdata[1]), .ef_a(ef_a[1]), .ef_d_o(ef_d_o[1]), .ef_d_oe(ef_d_oe[1]),
        .ef_d_i(ef_d_i), .flash_ce_n(flash_ce_n[1]), .flash_oe_n(flash_oe_n[1]), .flash_we_n(flash_we_n[1]),
        .enet_rd_n(enet_rd_n[1]), .enet_wr_n(enet_wr_n[1]), .enet_be_n(enet_be_n[1])
    );

    int    checks = 0;
    int    failures = 0;
    string where = "";

    // Reference model state: round-robin memory, last read data, last driven address.
    bit            last_en [2];
    logic [31:0]   rdata_old [2];
    logic [AW-1:0] efa_old [2];

    // Current access as the model sees it.
    bit            c_fl, c_we;
    logic [AW-1:0] c_adr;
    logic [31:0]   c_wd, c_rd;
    logic [3:0]    c_be;
    int            c_s, c_t, c_h;

    bit plan_fl, plan_fl_we, plan_en, plan_en_we;

    function automatic int p_setup(int d, bit fl);
        return (d == 0) ? (fl ? 2 : 1) : 0;
    endfunction
    function automatic int p_strobe(int d, bit fl);
        return (d == 0) ? (fl ? 4 : 3) : (fl ? 4 : 1);
    endfunction
    function automatic int p_hold(int d, bit fl);
        return (d == 0) ? 1 : (fl ? 0 : 2);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s @%s observed=%h expected=%h", tag, where, obs, exp);
        end
    endtask

    task automatic check_quiet(input int d);
        check("flash_ce_n", 32'(flash_ce_n[d]), 32'd1);
        check("flash_oe_n", 32'(flash_oe_n[d]), 32'd1);
        check("flash_we_n", 32'(flash_we_n[d]), 32'd1);
        check("enet_rd_n",  32'(enet_rd_n[d]),  32'd1);
        check("enet_wr_n",  32'(enet_wr_n[d]),  32'd1);
        check("enet_be_n",  32'(enet_be_n[d]),  32'hF);
        check("ef_d_oe",    32'(ef_d_oe[d]),    32'd0);
        check("fl_ack",     32'(fl_ack[d]),     32'd0);
        check("en_ack",     32'(en_ack[d]),     32'd0);
        check("ef_a",       32'(ef_a[d]),       32'(efa_old[d]));
        check("rdata",      rdata[d],           rdata_old[d]);
    endtask

    task automatic check_cycle(input int d, input int k);
        int          len;
        bit          stb;
        logic [31:0] exp_rd;
        len    = c_s + c_t + c_h;
        stb    = (k > c_s) && (k <= c_s + c_t);
        exp_rd = (!c_we && k > c_s + c_t) ? c_rd : rdata_old[d];
        where  = $sformatf("dut%0d cycle%0d", d, k);
        check("flash_ce_n", 32'(flash_ce_n[d]), 32'(!c_fl));
        check("flash_oe_n", 32'(flash_oe_n[d]), 32'(!(c_fl && stb && !c_we)));
        check("flash_we_n", 32'(flash_we_n[d]), 32'(!(c_fl && stb && c_we)));
        check("enet_rd_n",  32'(enet_rd_n[d]),  32'(!(!c_fl && stb && !c_we)));
        check("enet_wr_n",  32'(enet_wr_n[d]),  32'(!(!c_fl && stb && c_we)));
        check("enet_be_n",  32'(enet_be_n[d]),  32'(c_fl ? 4'hF : c_be));
        check("ef_a",       32'(ef_a[d]),       32'(c_adr));
        check("ef_d_oe",    32'(ef_d_oe[d]),    32'(c_we));
        if (c_we) check("ef_d_o", ef_d_o[d], c_wd);
        check("fl_ack",     32'(fl_ack[d]),     32'(c_fl && k == len));
        check("en_ack",     32'(en_ack[d]),     32'(!c_fl && k == len));
        check("rdata",      rdata[d],           exp_rd);
    endtask

    task automatic new_fl(input bit we);
        fl_we    = we;
        fl_adr   = AW'($urandom);
        fl_wdata = $urandom;
    endtask

    task automatic new_en(input bit we);
        en_we      = we;
        en_adr     = AW'($urandom);
        en_wdata   = $urandom;
        en_be_n_in = 4'($urandom);
    endtask

    // Model the grant decision for the requests currently presented to dut d.
    task automatic start(input int d, input logic [31:0] rdv);
        c_fl = (fl_req[d] && en_req[d]) ? last_en[d] : fl_req[d];
        last_en[d] = !c_fl;
        c_we  = c_fl ? fl_we : en_we;
        c_adr = c_fl ? fl_adr : en_adr;
        c_wd  = c_fl ? fl_wdata : en_wdata;
        c_be  = en_be_n_in;
        c_s   = p_setup(d, c_fl);
        c_t   = p_strobe(d, c_fl);
        c_h   = p_hold(d, c_fl);
        c_rd  = rdv;
        ef_d_i = $urandom;
    endtask

    // Entered in an IDLE cycle with requests presented; returns in the next IDLE cycle.
    task automatic run_one(input int d, input logic [31:0] rdv);
        start(d, rdv);
        for (int k = 1; k <= c_s + c_t + c_h; k++) begin
            @(posedge clk); #1;
            check_cycle(d, k);
            ef_d_i = (k == c_s + c_t) ? c_rd : $urandom;
        end
        if (!c_we) rdata_old[d] = c_rd;
        efa_old[d] = c_adr;
        @(posedge clk); #1;
        if (c_fl) fl_req[d] = 1'b0;
        else      en_req[d] = 1'b0;
        if (plan_fl && !fl_req[d]) begin new_fl(plan_fl_we); fl_req[d] = 1'b1; end
        if (plan_en && !en_req[d]) begin new_en(plan_en_we); en_req[d] = 1'b1; end
        plan_fl = 1'b0;
        plan_en = 1'b0;
        where = $sformatf("dut%0d gap", d);
        check_quiet(d);
        if (TURN && !c_we) begin
            @(posedge clk); #1;
            where = $sformatf("dut%0d turn", d);
            check_quiet(d);
        end
    endtask

    task automatic drain(input int d);
        for (int i = 0; i < 4 && (fl_req[d] || en_req[d]); i++) run_one(d, $urandom);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            last_en[d]   = 1'b1;
            rdata_old[d] = '0;
            efa_old[d]   = '0;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        fl_req = '0; en_req = '0;
        fl_we = 1'b0; en_we = 1'b0; fl_adr = '0; en_adr = '0;
        fl_wdata = '0; en_wdata = '0; en_be_n_in = 4'hF; ef_d_i = '0;
        plan_fl = 1'b0; plan_en = 1'b0; plan_fl_we = 1'b0; plan_en_we = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            where = $sformatf("dut%0d reset", d);
            check_quiet(d);
            check("ef_d_o", ef_d_o[d], 32'h0);
        end
        rst_n = 1'b1;

        // Flash read with 2/4/1 timing.
        new_fl(1'b0);
        fl_req[0] = 1'b1;
        run_one(0, 32'hCAFE_F00D);

        // Ethernet write with fixed address, byte enables and data.
        en_we = 1'b1; en_adr = 23'h000300; en_be_n_in = 4'hC; en_wdata = 32'h1234_5678;
        en_req[0] = 1'b1;
        run_one(0, $urandom);

        // Both requesters re-request continuously: grants must alternate, flash first.
        new_fl(1'($urandom)); new_en(1'($urandom));
        fl_req[0] = 1'b1; en_req[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            plan_fl = 1'b1; plan_fl_we = 1'($urandom);
            plan_en = 1'b1; plan_en_we = 1'($urandom);
            run_one(0, $urandom);
        end
        drain(0);

        // Read immediately followed by a write: the turnaround shows up as an extra quiet cycle.
        new_fl(1'b0);
        fl_req[0] = 1'b1;
        plan_en = 1'b1; plan_en_we = 1'b1;
        run_one(0, $urandom);
        run_one(0, $urandom);

        // Zero setup/hold flash and strobe-0 Ethernet on the second instance.
        new_fl(1'b0); fl_req[1] = 1'b1; run_one(1, $urandom);
        new_fl(1'b1); fl_req[1] = 1'b1; run_one(1, $urandom);
        new_en(1'b0); en_req[1] = 1'b1; run_one(1, $urandom);
        new_en(1'b1); en_req[1] = 1'b1; run_one(1, $urandom);

        // Randomized request mixes on both instances.
        for (int i = 0; i < 24; i++) begin
            int d, r;
            d = int'($urandom_range(0, 1));
            r = int'($urandom_range(1, 3));
            if (r[0]) begin new_fl(1'($urandom)); fl_req[d] = 1'b1; end
            if (r[1]) begin new_en(1'($urandom)); en_req[d] = 1'b1; end
            plan_fl = 1'($urandom); plan_fl_we = 1'($urandom);
            plan_en = 1'($urandom); plan_en_we = 1'($urandom);
            run_one(d, $urandom);
            drain(d);
        end

        // Reset in the middle of a flash read strobe: no ack, then the re-issued read completes.
        new_fl(1'b0);
        fl_req[0] = 1'b1;
        start(0, 32'h5A5A_0FF0);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            check_cycle(0, k);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        model_reset();
        fl_req[0] = 1'b0;
        for (int d = 0; d < 2; d++) begin
            where = $sformatf("dut%0d mid-reset", d);
            check_quiet(d);
        end
        rst_n = 1'b1;
        fl_req[0] = 1'b1;
        run_one(0, 32'hCAFE_F00D);
        new_en(1'b0); fl_req[0] = 1'b1; en_req[0] = 1'b1;
        run_one(0, $urandom);
        drain(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
